clk_ratio_lock_detect: RTL and testbench

CLK_RATIO_LOCK_DETECT -- requirements
Module: clk_ratio_lock_detect

---
 rtl/clk_ratio_lock_detect.sv | 143 ++++++++++++++
 tb/tb_clk_ratio_lock_detect.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_lock_detect.sv
// clk_ratio_lock_detect
// Counts transitions of a divided clock (mon_tgl) over fixed windows of
// clk_in1 cycles and declares lock after LOCK_COUNT consecutive windows whose
// count lies within EXPECTED +/- TOLERANCE.
//
// Output timing: meas_count, meas_valid, locked and lost_lock are all
// registered.  On the clock edge that closes a window they update together, so
// the meas_valid pulse is seen in the cycle after the window-end cycle.
// fsm_state is a debug copy of the controller state (0 idle, 1 flush, 2 measure).
module clk_ratio_lock_detect #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int EXPECTED      = 256,
  parameter int TOLERANCE     = 2,
  parameter int LOCK_COUNT    = 3
) (
  input  logic        clk_in1,
  input  logic        reset,
  input  logic        enable,
  input  logic        mon_tgl,
  output logic        locked,
  output logic [15:0] meas_count,
  output logic        meas_valid,
  output logic        lost_lock,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  // Good-window bounds in 17-bit signed arithmetic; the lower bound is clamped
  // at zero so a large tolerance can never wrap into a huge unsigned value.
  localparam int LO_INT = (EXPECTED - TOLERANCE < 0) ? 0 : (EXPECTED - TOLERANCE);
  localparam int HI_INT = EXPECTED + TOLERANCE;
  localparam logic signed [16:0] LO_BOUND = 17'(LO_INT);
  localparam logic signed [16:0] HI_BOUND = 17'(HI_INT);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_COUNT);

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        hist;
  logic        flush_cnt;
  logic [15:0] win_cnt;
  logic [15:0] edge_cnt;
  logic [3:0]  streak;

  logic        edge_det;
  logic [15:0] edge_sum;
  logic        count_good;
  logic [3:0]  streak_inc;

  assign fsm_state = state;

  // Edge seen this cycle; it is folded into the running count including on the
  // window-end cycle, so edge_sum is the final count of the ending window.
  assign edge_det   = sync2 ^ hist;
  assign edge_sum   = (edge_cnt == 16'hFFFF) ? edge_cnt : (edge_cnt + {15'd0, edge_det});
  assign count_good = ($signed({1'b0, edge_sum}) >= LO_BOUND) &&
                      ($signed({1'b0, edge_sum}) <= HI_BOUND);
  assign streak_inc = (streak >= LOCK_N) ? LOCK_N : (streak + 4'd1);

  // Two-flop synchronizer for the asynchronous toggle plus a history flop.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= mon_tgl;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Controller: idle/flush/measure, window and edge counting, lock tracking.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state      <= S_IDLE;
      flush_cnt  <= 1'b0;
      win_cnt    <= 16'd0;
      edge_cnt   <= 16'd0;
      streak     <= 4'd0;
      locked     <= 1'b0;
      meas_count <= 16'd0;
      meas_valid <= 1'b0;
      lost_lock  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      lost_lock  <= 1'b0;
      if (!enable) begin
        // Disabling is not a lock failure: drop lock quietly, keep meas_count.
        state     <= S_IDLE;
        flush_cnt <= 1'b0;
        win_cnt   <= 16'd0;
        edge_cnt  <= 16'd0;
        streak    <= 4'd0;
        locked    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_FLUSH;
            flush_cnt <= 1'b0;
          end
          S_FLUSH: begin
            // Two cycles with edges ignored while the history flop refills.
            if (flush_cnt) begin
              state    <= S_MEASURE;
              win_cnt  <= 16'd0;
              edge_cnt <= 16'd0;
            end else begin
              flush_cnt <= 1'b1;
            end
          end
          S_MEASURE: begin
            if (win_cnt == WIN_LAST) begin
              meas_count <= edge_sum;
              meas_valid <= 1'b1;
              win_cnt    <= 16'd0;
              edge_cnt   <= 16'd0;
              if (count_good) begin
                streak <= streak_inc;
                locked <= (streak_inc == LOCK_N);
              end else begin
                streak    <= 4'd0;
                locked    <= 1'b0;
                lost_lock <= locked;
              end
            end else begin
              win_cnt  <= win_cnt + 16'd1;
              edge_cnt <= edge_sum;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_lock_detect.sv
// tb_clk_ratio_lock_detect
// Bench for clk_ratio_lock_detect with 64-cycle windows, 16 +/- 1 expected
// transitions and a lock streak of 3.  A reference model keeps the full history
// of driven mon_tgl values and, when a window closes, counts the transitions
// that fell inside it; every cycle all outputs are compared with the model.
module tb_clk_ratio_lock_detect;

  localparam int WIN   = 64;
  localparam int EXPN  = 16;
  localparam int TOL   = 1;
  localparam int LOCKN = 3;
  localparam int LO    = (EXPN - TOL < 0) ? 0 : (EXPN - TOL);
  localparam int HI    = EXPN + TOL;

  localparam int M_IDLE  = 0;
  localparam int M_FLUSH = 1;
  localparam int M_MEAS  = 2;

  localparam int P_CONST  = 0;
  localparam int P_PERIOD = 1;
  localparam int P_COUNT  = 2;
  localparam int P_RAND   = 3;

  // ---------------- clock / reset ----------------
  logic        clk_in1 = 1'b0;
  logic        reset   = 1'b1;
  logic        enable  = 1'b0;
  logic        mon_tgl = 1'b0;
  logic        locked;
  logic [15:0] meas_count;
  logic        meas_valid;
  logic        lost_lock;
  logic [1:0]  fsm_state;

  always #5 clk_in1 = ~clk_in1;

  clk_ratio_lock_detect #(
    .WINDOW_CYCLES(WIN),
    .EXPECTED(EXPN),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LOCKN)
  ) dut (
    .clk_in1(clk_in1),
    .reset(reset),
    .enable(enable),
    .mon_tgl(mon_tgl),
    .locked(locked),
    .meas_count(meas_count),
    .meas_valid(meas_valid),
    .lost_lock(lost_lock),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit          mh[$];
  logic [15:0] exp_q[$];
  int          m_st     = M_IDLE;
  int          m_fl     = 0;
  int          m_pos    = 0;
  int          m_wstart = 0;
  int          m_streak = 0;
  bit          e_locked = 1'b0;
  bit          e_valid  = 1'b0;
  bit          e_lost   = 1'b0;
  int          e_count  = 0;

  typedef struct {
    int mode;
    int param;
    bit end_edge;
    int windows;
    int exp_count;   // -1: not checked
    int exp_locked;
    int exp_lost;    // 1 if a lost_lock pulse must be seen in the scenario
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advance by one clock edge given the sampled controls.
  task automatic model_step(input bit rst, input bit en);
    int n;
    int cnt;
    n       = mh.size() - 1;
    e_valid = 1'b0;
    e_lost  = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_streak = 0; e_locked = 1'b0; e_count = 0;
    end else if (!en) begin
      m_st = M_IDLE; m_streak = 0; e_locked = 1'b0;
    end else if (m_st == M_IDLE) begin
      m_st = M_FLUSH; m_fl = 0;
    end else if (m_st == M_FLUSH) begin
      if (m_fl == 1) begin
        m_st = M_MEAS; m_pos = 0; m_wstart = n + 1;
      end else begin
        m_fl = 1;
      end
    end else if (m_pos == WIN - 1) begin
      // A mon_tgl change between samples k-3 and k-2 is counted on edge k.
      cnt = 0;
      for (int k = m_wstart; k <= n; k++)
        if (mh[k-2] != mh[k-3]) cnt++;
      if (cnt > 65535) cnt = 65535;
      e_count = cnt;
      e_valid = 1'b1;
      exp_q.push_back(16'(cnt));
      if (cnt >= LO && cnt <= HI) begin
        m_streak = (m_streak + 1 > LOCKN) ? LOCKN : m_streak + 1;
        e_locked = (m_streak == LOCKN);
      end else begin
        e_lost   = e_locked;
        e_locked = 1'b0;
        m_streak = 0;
      end
      m_pos    = 0;
      m_wstart = n + 1;
    end else begin
      m_pos++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [15:0] w;
    mh.push_back(mon_tgl);
    @(posedge clk_in1);
    #1;
    model_step(reset, enable);
    check("locked", locked, e_locked);
    check("meas_valid", meas_valid, e_valid);
    check("lost_lock", lost_lock, e_lost);
    check("meas_count", meas_count, e_count);
    if (meas_valid) begin
      check("window_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("window_count", meas_count, w);
      end
    end
    cyc++;
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (!(m_st == M_MEAS && m_pos == p) && n < 300) begin
      tick();
      n++;
    end
    check("reach_window_pos", n < 300, 1);
  endtask

  task automatic run_pattern(input int mode, input int param, input bit end_edge,
                             input int windows, output bit lost_seen);
    lost_seen = 1'b0;
    repeat (windows * WIN) begin
      int q;
      bit tg;
      q  = m_pos;
      tg = 1'b0;
      case (mode)
        P_PERIOD: tg = ((q % param) == 0);
        P_COUNT:  tg = ((q % 3) == 1 && (q / 3) < param) || (end_edge && q == 61);
        P_RAND:   tg = ($urandom_range(0, 3) == 0);
        default:  tg = 1'b0;
      endcase
      if (tg) mon_tgl = ~mon_tgl;
      tick();
      if (lost_lock) lost_seen = 1'b1;
    end
  endtask

  // Toggle every 4 cycles until meas_valid; returns ticks taken.
  task automatic ticks_to_valid(output int n);
    n = 0;
    do begin
      if ((n % 4) == 0) mon_tgl = ~mon_tgl;
      tick();
      n++;
    end while (!meas_valid && n < 200);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    bit lost_seen;
    int n;
    int dens;

    vecs[0]  = '{P_PERIOD, 4, 1'b0, 2, 16, 0, 0};
    vecs[1]  = '{P_PERIOD, 4, 1'b0, 1, 16, 1, 0};
    vecs[2]  = '{P_PERIOD, 3, 1'b0, 1, 21, 0, 1};
    vecs[3]  = '{P_PERIOD, 4, 1'b0, 2, 16, 0, 0};
    vecs[4]  = '{P_PERIOD, 4, 1'b0, 1, 16, 1, 0};
    vecs[5]  = '{P_COUNT, 15, 1'b0, 1, 15, 1, 0};
    vecs[6]  = '{P_COUNT, 17, 1'b0, 1, 17, 1, 0};
    vecs[7]  = '{P_COUNT, 14, 1'b0, 1, 14, 0, 1};
    vecs[8]  = '{P_COUNT, 18, 1'b0, 1, 18, 0, 0};
    vecs[9]  = '{P_COUNT, 15, 1'b1, 3, 16, 1, 0};
    vecs[10] = '{P_CONST, 0, 1'b0, 2, 0, 0, 1};
    vecs[11] = '{P_CONST, 0, 1'b0, 2, 0, 0, 0};
    vecs[12] = '{P_RAND, 0, 1'b0, 4, -1, -1, -1};

    // Reset state
    reset = 1'b1; enable = 1'b1; mon_tgl = 1'b0;
    repeat (4) tick();
    check("rst_locked", locked, 0);
    check("rst_meas_count", meas_count, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_lost_lock", lost_lock, 0);
    reset = 1'b0;

    // Table-driven scenarios, each aligned to a window start
    foreach (vecs[i]) begin
      wait_pos(0);
      run_pattern(vecs[i].mode, vecs[i].param, vecs[i].end_edge, vecs[i].windows, lost_seen);
      if (vecs[i].exp_count >= 0)  check($sformatf("vec%0d_count", i), meas_count, vecs[i].exp_count);
      if (vecs[i].exp_locked >= 0) check($sformatf("vec%0d_locked", i), locked, vecs[i].exp_locked);
      if (vecs[i].exp_lost >= 0)   check($sformatf("vec%0d_lost_seen", i), lost_seen, vecs[i].exp_lost);
    end

    // Enable dropped while locked, then re-enabled
    wait_pos(0);
    run_pattern(P_PERIOD, 4, 1'b0, 3, lost_seen);
    check("h1_locked_before", locked, 1);
    wait_pos(20);
    enable = 1'b0;
    tick();
    check("h1_locked_after_disable", locked, 0);
    check("h1_no_lost_lock", lost_lock, 0);
    repeat (4) tick();
    enable = 1'b1;
    ticks_to_valid(n);
    check("h1_reenable_latency", n, 67);

    // Reset at window cycle 40 while locked
    wait_pos(0);
    run_pattern(P_PERIOD, 4, 1'b0, 3, lost_seen);
    check("h2_locked_before", locked, 1);
    wait_pos(40);
    reset = 1'b1;
    tick();
    check("h2_locked", locked, 0);
    check("h2_meas_count", meas_count, 0);
    check("h2_meas_valid", meas_valid, 0);
    check("h2_lost_lock", lost_lock, 0);
    reset = 1'b0;
    ticks_to_valid(n);
    check("h2_first_valid_latency", n, 67);

    // Reset on the window-end cycle wins over the window close
    wait_pos(63);
    reset = 1'b1;
    tick();
    check("h3_meas_valid", meas_valid, 0);
    check("h3_meas_count", meas_count, 0);
    reset = 1'b0;

    // Randomized toggling density, enable drops and rare resets
    dens = 25;
    for (int i = 0; i < 1500; i++) begin
      if ((i % WIN) == 0) dens = 20 + 4 * $urandom_range(0, 3);
      if ($urandom_range(0, 99) < dens) mon_tgl = ~mon_tgl;
      if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      else if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset  = 1'b0;
    enable = 1'b1;
    repeat (4) tick();
    check("window_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
